// File: rtl/alu_mp_sequencer.sv
// Multi-byte ALU sequencer: runs one NBYTES x 8 operation through an 8-bit ALU, LSB first, with carry chaining.
// Optional opcode 011 (W-bit shift left by one) is compiled in when ALU_SEQ_SHL1_EN is defined.
module alu_mp_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_flag,
  output logic                  zero_flag,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_carry_in,
  output logic                  alu_is_shift,
  output logic [1:0]            alu_scode,
  output logic [2:0]            alu_acode,
  input  logic [7:0]            alu_r,
  input  logic                  alu_carry_out
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SHL1 = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            idx;
  logic                     chain;
  logic [2:0]               opc_q;
  logic [NBYTES-1:0][7:0]   a_q, b_q, work, work_c;
  logic                     nz;
  logic                     op_ok_c, last_c, chain_nxt_c;
  logic [7:0]               cap_c;

  assign last_c = (idx == IW'(NBYTES - 1));

  // Opcodes that run the byte loop; anything else completes without touching state
  always_comb begin
    op_ok_c = 1'b1;
    case (opcode)
      OP_RSVD: op_ok_c = 1'b0;
`ifndef ALU_SEQ_SHL1_EN
      OP_SHL1: op_ok_c = 1'b0;
`endif
      default: ;
    endcase
  end

  // State register; busy/done are flopped from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = op_ok_c ? S_RUN : S_DONE;
      S_RUN:  if (last_c) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU drive for the current byte, plus the byte to capture and the carry to chain
  always_comb begin
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_carry_in = 1'b0;
    alu_is_shift = 1'b0;
    alu_scode    = 2'b00;
    alu_acode    = 3'b000;
    cap_c        = alu_r;
    chain_nxt_c  = 1'b0;
    if (state == S_RUN) begin
      alu_a = a_q[idx];
      case (opc_q)
        OP_ADD, OP_ADC: begin
          alu_b        = b_q[idx];
          alu_acode    = 3'b001;
          alu_carry_in = chain;
          chain_nxt_c  = alu_carry_out;
        end
        OP_SUB: begin
          alu_b        = ~b_q[idx];
          alu_acode    = 3'b001;
          alu_carry_in = chain;
          chain_nxt_c  = alu_carry_out;
        end
        OP_AND: begin
          alu_b     = b_q[idx];
          alu_acode = 3'b100;
        end
        OP_OR: begin
          alu_b     = b_q[idx];
          alu_acode = 3'b101;
        end
        OP_XOR: begin
          alu_b     = b_q[idx];
          alu_acode = 3'b110;
        end
`ifdef ALU_SEQ_SHL1_EN
        OP_SHL1: begin
          alu_is_shift = 1'b1;
          alu_b        = 8'd1;
          cap_c        = {alu_r[7:1], chain};
          chain_nxt_c  = alu_carry_out;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    work_c      = work;
    work_c[idx] = cap_c;
  end

  // Datapath: operand latch at accept, byte capture in RUN, architectural update on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      chain      <= 1'b0;
      opc_q      <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      work       <= '0;
      nz         <= 1'b0;
      result     <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          opc_q <= opcode;
          a_q   <= op_a;
          b_q   <= op_b;
          work  <= '0;
          nz    <= 1'b0;
          idx   <= '0;
          chain <= (opcode == OP_SUB) ? 1'b1 : ((opcode == OP_ADC) ? carry_flag : 1'b0);
        end
        S_RUN: begin
          work  <= work_c;
          chain <= chain_nxt_c;
          nz    <= nz | (|cap_c);
          idx   <= last_c ? '0 : idx + IW'(1);
          if (last_c) begin
            result     <= work_c;
            carry_flag <= chain_nxt_c;
            zero_flag  <= ~(nz | (|cap_c));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Self-checking bench for alu_mp_sequencer: behavioural 8-bit ALU plus a whole-word reference model.
module tb_alu_mp_sequencer;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W = 8 * NBYTES;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SHL1 = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [2:0]   opcode;
  logic [W-1:0] op_a, op_b, result;
  logic         busy, done, carry_flag, zero_flag;
  logic [7:0]   alu_a, alu_b, alu_r;
  logic         alu_carry_in, alu_is_shift, alu_carry_out;
  logic [1:0]   alu_scode;
  logic [2:0]   alu_acode;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] m_result;
  logic         m_cf, m_zf;
  bit           cin_q[$];
  bit           shift_seen;

  always #5 clk = ~clk;

  alu_mp_sequencer #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_is_shift(alu_is_shift),
    .alu_scode(alu_scode), .alu_acode(alu_acode), .alu_r(alu_r), .alu_carry_out(alu_carry_out)
  );

  // Behavioural 8-bit ALU: true bit-8 carry for add, A[7] out on shift
  always_comb begin
    alu_r = 8'h00;
    alu_carry_out = 1'b0;
    if (alu_is_shift) begin
      alu_r = {alu_a[6:0], 1'b0};
      alu_carry_out = alu_a[7];
    end else begin
      case (alu_acode)
        3'b001: {alu_carry_out, alu_r} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_carry_in);
        3'b100: alu_r = alu_a & alu_b;
        3'b101: alu_r = alu_a | alu_b;
        3'b110: alu_r = alu_a ^ alu_b;
        default: ;
      endcase
    end
  end

  // Whole-word reference: updates model flags/result and returns the expected edge count
  task automatic ref_apply(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int exp_edges);
    logic [W:0] s;
    bit valid;
    valid = 1'b1;
    case (opc)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; m_result = s[W-1:0]; m_cf = s[W]; end
      OP_ADC: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(m_cf); m_result = s[W-1:0]; m_cf = s[W]; end
      OP_SUB: begin m_result = a - b; m_cf = (a >= b); end
      OP_AND: begin m_result = a & b; m_cf = 1'b0; end
      OP_OR:  begin m_result = a | b; m_cf = 1'b0; end
      OP_XOR: begin m_result = a ^ b; m_cf = 1'b0; end
`ifdef ALU_SEQ_SHL1_EN
      OP_SHL1: begin m_result = a << 1; m_cf = a[W-1]; end
`endif
      default: valid = 1'b0;
    endcase
    if (valid) m_zf = (m_result == '0);
    exp_edges = valid ? NBYTES + 1 : 1;
  endtask

  // Issue one op, scramble inputs while busy, and count edges from the start edge to done
  task automatic issue(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int edges, output bit ok);
    @(negedge clk);
    start = 1'b1; opcode = opc; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; edges = 1; ok = 1'b0;
    cin_q.delete(); shift_seen = 1'b0;
    op_a = W'({$urandom, $urandom}); op_b = W'({$urandom, $urandom}); opcode = 3'($urandom);
    for (int k = 0; k < 4 * NBYTES + 8; k++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) cin_q.push_back(alu_carry_in);
      if (alu_is_shift) shift_seen = 1'b1;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    int e; bit ok;
    checks++;
    if ({busy, done, carry_flag, zero_flag} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("FAIL reset_init: busy/done/cf/zf=%b result=%h exp 0000/0", {busy, done, carry_flag, zero_flag}, result);
    end
    @(negedge clk); rst_n = 1'b1;
    ref_apply(OP_SUB, 32'd5, 32'd1, e);
    issue(OP_SUB, 32'd5, 32'd1, e, ok);
    checks++;
    if (!ok || result !== m_result || carry_flag !== m_cf) begin
      errors++;
      $display("FAIL reset_setup: ok=%0b result=%h cf=%b exp result=%h cf=%b", ok, result, carry_flag, m_result, m_cf);
    end
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD; op_a = 32'h11223344; op_b = 32'h01010101;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_result = '0; m_cf = 1'b0; m_zf = 1'b0;
    checks++;
    if ({busy, done, carry_flag, zero_flag} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("FAIL reset_async: busy/done/cf/zf=%b result=%h exp 0000/0", {busy, done, carry_flag, zero_flag}, result);
    end
    checks++;
    if ({alu_a, alu_b, alu_carry_in, alu_is_shift, alu_scode, alu_acode} !== 23'd0) begin
      errors++;
      $display("FAIL reset_alu_side: a=%h b=%h cin=%b acode=%b exp all 0", alu_a, alu_b, alu_carry_in, alu_acode);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    int e, ee; bit ok; logic [NBYTES-1:0] got_cin;
    ref_apply(OP_ADD, 32'h000000FF, 32'h00000001, ee);
    issue(OP_ADD, 32'h000000FF, 32'h00000001, e, ok);
    checks++;
    if (!ok || e != ee) begin errors++; $display("FAIL add_latency: ok=%0b edges=%0d exp %0d", ok, e, ee); end
    checks++;
    if (result !== 32'h00000100 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL add_result: result=%h cf=%b zf=%b exp 00000100 0 0", result, carry_flag, zero_flag);
    end
    got_cin = '0;
    foreach (cin_q[i]) if (i < NBYTES) got_cin[i] = cin_q[i];
    checks++;
    if (cin_q.size() != NBYTES || got_cin !== 4'b0010) begin
      errors++;
      $display("FAIL add_carry_chain: n=%0d cin=%b exp n=%0d cin=0010 (byte0 in bit0)", cin_q.size(), got_cin, NBYTES);
    end
  endtask

  task automatic test_sub();
    int e; bit ok;
    ref_apply(OP_SUB, 32'h00000100, 32'h00000001, e);
    issue(OP_SUB, 32'h00000100, 32'h00000001, e, ok);
    checks++;
    if (!ok || result !== 32'h000000FF || carry_flag !== 1'b1) begin
      errors++;
      $display("FAIL sub_no_borrow: result=%h cf=%b exp 000000ff 1", result, carry_flag);
    end
    ref_apply(OP_SUB, 32'h00000000, 32'h00000001, e);
    issue(OP_SUB, 32'h00000000, 32'h00000001, e, ok);
    checks++;
    if (!ok || result !== 32'hFFFFFFFF || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: result=%h cf=%b zf=%b exp ffffffff 0 0", result, carry_flag, zero_flag);
    end
  endtask

  task automatic test_adc();
    int e; bit ok;
    ref_apply(OP_ADD, 32'hFFFFFFFF, 32'h00000001, e);
    issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, e, ok);
    checks++;
    if (!ok || carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
      errors++;
      $display("FAIL adc_setup: cf=%b zf=%b exp 1 1", carry_flag, zero_flag);
    end
    ref_apply(OP_ADC, 32'hFFFFFFFF, 32'h00000000, e);
    issue(OP_ADC, 32'hFFFFFFFF, 32'h00000000, e, ok);
    checks++;
    if (!ok || result !== 32'h00000000 || carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
      errors++;
      $display("FAIL adc_carry_in: result=%h cf=%b zf=%b exp 00000000 1 1", result, carry_flag, zero_flag);
    end
  endtask

  task automatic test_logic();
    int e; bit ok;
    ref_apply(OP_XOR, 32'hA5A5A5A5, 32'hA5A5A5A5, e);
    issue(OP_XOR, 32'hA5A5A5A5, 32'hA5A5A5A5, e, ok);
    checks++;
    if (!ok || result !== 32'h0 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
      errors++;
      $display("FAIL xor_zero: result=%h cf=%b zf=%b exp 00000000 0 1", result, carry_flag, zero_flag);
    end
    ref_apply(OP_OR, 32'h12340000, 32'h00005678, e);
    issue(OP_OR, 32'h12340000, 32'h00005678, e, ok);
    checks++;
    if (!ok || result !== 32'h12345678 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL or_basic: result=%h zf=%b exp 12345678 0", result, zero_flag);
    end
  endtask

  task automatic test_reserved();
    int e; bit ok;
    issue(OP_RSVD, 32'hDEADBEEF, 32'h1, e, ok);
    checks++;
    if (!ok || e != 1 || cin_q.size() != 0) begin
      errors++;
      $display("FAIL rsvd_latency: ok=%0b edges=%0d run_bytes=%0d exp 1 0", ok, e, cin_q.size());
    end
    checks++;
    if (result !== m_result || carry_flag !== m_cf || zero_flag !== m_zf) begin
      errors++;
      $display("FAIL rsvd_unchanged: result=%h cf=%b zf=%b exp %h %b %b", result, carry_flag, zero_flag, m_result, m_cf, m_zf);
    end
  endtask

  task automatic test_shl1();
    int e, ee; bit ok;
    ref_apply(OP_SHL1, 32'h80808081, 32'h0, ee);
    issue(OP_SHL1, 32'h80808081, 32'h0, e, ok);
    checks++;
`ifdef ALU_SEQ_SHL1_EN
    if (!ok || e != ee || result !== 32'h01010102 || carry_flag !== 1'b1) begin
      errors++;
      $display("FAIL shl1: edges=%0d result=%h cf=%b exp %0d 01010102 1", e, result, carry_flag, ee);
    end
`else
    if (!ok || e != 1 || shift_seen || result !== m_result || carry_flag !== m_cf || zero_flag !== m_zf) begin
      errors++;
      $display("FAIL op011_reserved: edges=%0d shift=%b result=%h cf=%b exp 1 0 %h %b", e, shift_seen, result, carry_flag, m_result, m_cf);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int e; bit ok;
    ref_apply(OP_ADD, 32'h01020304, 32'h10203040, e);
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD; op_a = 32'h01020304; op_b = 32'h10203040;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; opcode = OP_SUB; op_a = 32'hFFFFFFFF; op_b = 32'h1;
    @(negedge clk); start = 1'b0;
    e = 3; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk); e++;
    end
    checks++;
    if (!ok || e != NBYTES + 1 || result !== 32'h11223344) begin
      errors++;
      $display("FAIL start_in_run: ok=%0b edges=%0d result=%h exp %0d 11223344", ok, e, result, NBYTES + 1);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy=%b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int e, gap; bit ok;
    ref_apply(OP_ADD, 32'h00FF00FF, 32'h00010001, e);
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD; op_a = 32'h00FF00FF; op_b = 32'h00010001;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    gap = 0;
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk); gap++;
        if (done) begin ok = 1'b1; break; end
      end
    end
    start = 1'b0;
    checks++;
    if (!ok || gap != NBYTES + 2 || result !== 32'h01000100) begin
      errors++;
      $display("FAIL back_to_back: ok=%0b gap=%0d result=%h exp %0d 01000100", ok, gap, result, NBYTES + 2);
    end
  endtask

  task automatic test_random();
    int e, ee; bit ok, arith, c0;
    logic [2:0] opc; logic [W-1:0] a, b, bv, x; logic [W:0] s;
    logic [NBYTES-1:0] exp_cin, got_cin;
    for (int n = 0; n < 40; n++) begin
      opc = 3'($urandom_range(0, 7));
      a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom});
      case ($urandom_range(0, 3))
        1: b = a;
        2: begin a = '0; b = W'($urandom_range(0, 3)); end
        3: a = '1;
        default: ;
      endcase
      arith = (opc == OP_ADD || opc == OP_ADC || opc == OP_SUB);
      bv = (opc == OP_SUB) ? ~b : b;
      c0 = (opc == OP_SUB) ? 1'b1 : ((opc == OP_ADC) ? m_cf : 1'b0);
      s = {1'b0, a} + {1'b0, bv} + (W+1)'(c0);
      x = s[W-1:0] ^ a ^ bv;
      for (int i = 0; i < NBYTES; i++) exp_cin[i] = arith & x[8*i];
      ref_apply(opc, a, b, ee);
      issue(opc, a, b, e, ok);
      got_cin = '0;
      foreach (cin_q[i]) if (i < NBYTES) got_cin[i] = cin_q[i];
      if (ee == 1) exp_cin = '0;
      checks++;
      if (!ok || e != ee || result !== m_result || carry_flag !== m_cf || zero_flag !== m_zf ||
          got_cin !== exp_cin || cin_q.size() != ((ee == 1) ? 0 : NBYTES) ||
          shift_seen !== (opc == OP_SHL1 && ee != 1)) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h: edges=%0d result=%h cf=%b zf=%b cin=%b sh=%b exp %0d %h %b %b %b",
                 opc, a, b, e, result, carry_flag, zero_flag, got_cin, shift_seen, ee, m_result, m_cf, m_zf, exp_cin);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 3'b000; op_a = '0; op_b = '0;
    m_result = '0; m_cf = 1'b0; m_zf = 1'b0; shift_seen = 1'b0;
    #12;
    test_reset();
    test_add();
    test_sub();
    test_adc();
    test_logic();
    test_reserved();
    test_shl1();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
